// File: rtl/matrix_mac_engine_pkg.sv
// Shared constants, coefficient matrix and FSM state type for the matrix MAC engine.
// Y = COEF x X; results are wide enough that the 4-term sum never overflows.
package matrix_mac_engine_pkg;

    localparam int DATA_W = 8;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 8;
    localparam int ACC_W  = 2 * DATA_W + $clog2(N_ROWS);
    localparam int ROW_W  = $clog2(N_ROWS);
    localparam int COL_W  = $clog2(N_COLS);

    typedef logic [N_ROWS-1:0][N_ROWS-1:0][DATA_W-1:0] coef_t;

    // Packed, so each row and each entry are written from index 3 down to 0.
    // Natural order: row0 {3,1,4,1}, row1 {5,9,2,6}, row2 {255,0,7,128}, row3 {2,200,17,1}.
    localparam coef_t COEF = {
        {8'd1,   8'd17, 8'd200, 8'd2},
        {8'd128, 8'd7,  8'd0,   8'd255},
        {8'd6,   8'd2,  8'd9,   8'd5},
        {8'd1,   8'd4,  8'd1,   8'd3}
    };

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CALC,
        FIN
    } state_e;

endpackage

// File: rtl/matrix_mac_engine_if.sv
// Loader-facing and result-facing signals of the matrix MAC engine.
interface matrix_mac_engine_if;
    import matrix_mac_engine_pkg::*;

    logic              start;
    logic [DATA_W-1:0] element1;
    logic [DATA_W-1:0] element2;
    logic [DATA_W-1:0] element3;
    logic [DATA_W-1:0] element4;
    logic              input_ready;
    logic              input_start;
    logic [ACC_W-1:0]  result;
    logic [ROW_W-1:0]  result_row;
    logic [COL_W-1:0]  result_col;
    logic              result_valid;
    logic              busy;
    logic              done;

    // Handshake: start, input_ready, input_start and done are single-cycle strobes with no
    // back-pressure; element1..4 are sampled only when input_ready is high in the WAIT state,
    // and the result fields are meaningful only in cycles where result_valid is high.
    modport master (
        output start, element1, element2, element3, element4, input_ready,
        input  input_start, result, result_row, result_col, result_valid, busy, done
    );

    modport slave (
        input  start, element1, element2, element3, element4, input_ready,
        output input_start, result, result_row, result_col, result_valid, busy, done
    );

endinterface

// File: rtl/matrix_mac_engine_mac_dot4.sv
// Combinational unsigned dot product of one coefficient row with the latched column.
module mac_dot4
    import matrix_mac_engine_pkg::*;
(
    input  logic [N_ROWS-1:0][DATA_W-1:0] coef,
    input  logic [N_ROWS-1:0][DATA_W-1:0] data,
    output logic [ACC_W-1:0]              dot
);

    logic [2*DATA_W-1:0] prod [N_ROWS];
    logic [ACC_W-1:0]    sum_lo;
    logic [ACC_W-1:0]    sum_hi;

    always_comb begin
        for (int k = 0; k < N_ROWS; k++) begin
            prod[k] = (2*DATA_W)'(coef[k]) * (2*DATA_W)'(data[k]);
        end
        // Zero-extended two-level adder tree.
        sum_lo = ACC_W'(prod[0]) + ACC_W'(prod[1]);
        sum_hi = ACC_W'(prod[2]) + ACC_W'(prod[3]);
        dot    = sum_lo + sum_hi;
    end

endmodule

// File: rtl/matrix_mac_engine.sv
// Requests the 8 loader columns one at a time and streams Y = COEF x X column-major.
// FSM, counters and all output registers live here; the arithmetic is in mac_dot4.
module matrix_mac_engine
    import matrix_mac_engine_pkg::*;
#(
    parameter coef_t COEFS = COEF
) (
    input  logic               clk,
    input  logic               reset,
    matrix_mac_engine_if.slave bus,
    output state_e             dbg_state
);

    state_e                        state;
    state_e                        state_nxt;
    logic [ROW_W-1:0]              row;
    logic [COL_W-1:0]              col;
    logic [N_ROWS-1:0][DATA_W-1:0] col_reg;
    logic [N_ROWS-1:0][DATA_W-1:0] coef_row;
    logic [ACC_W-1:0]              dot;
    logic                          last_row;
    logic                          last_col;

    logic input_start_nxt;
    logic busy_nxt;
    logic done_nxt;
    logic valid_nxt;

    logic             input_start_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic [ACC_W-1:0] result_q;
    logic [ROW_W-1:0] result_row_q;
    logic [COL_W-1:0] result_col_q;

    assign last_row = (row == ROW_W'(N_ROWS - 1));
    assign last_col = (col == COL_W'(N_COLS - 1));

    mac_dot4 u_dot (
        .coef (coef_row),
        .data (col_reg),
        .dot  (dot)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            row           <= '0;
            col           <= '0;
            col_reg       <= '0;
            input_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            result_q      <= '0;
            result_row_q  <= '0;
            result_col_q  <= '0;
        end else begin
            state         <= state_nxt;
            input_start_q <= input_start_nxt;
            busy_q        <= busy_nxt;
            done_q        <= done_nxt;
            valid_q       <= valid_nxt;

            if (state == WAIT && bus.input_ready) begin
                col_reg <= {bus.element4, bus.element3, bus.element2, bus.element1};
                row     <= '0;
            end

            if (state == CALC) begin
                result_q     <= dot;
                result_row_q <= row;
                result_col_q <= col;
                row          <= row + ROW_W'(1);
                if (last_row && !last_col) begin
                    col <= col + COL_W'(1);
                end
            end

            if (state == FIN) begin
                col <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    if (bus.input_ready) state_nxt = CALC;
            CALC:    if (last_row) state_nxt = last_col ? FIN : REQ;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; input_start is a pulse on entry to REQ only,
    // since the loader rotates once per high cycle.
    always_comb begin
        input_start_nxt = (state_nxt == REQ) && (state != REQ);
        busy_nxt        = (state_nxt != IDLE);
        done_nxt        = (state_nxt == FIN);
        valid_nxt       = (state == CALC);
        coef_row        = COEFS[row];
    end

    assign bus.input_start  = input_start_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
    assign bus.result_row   = result_row_q;
    assign bus.result_col   = result_col_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: three instances (package, identity and all-255
// coefficients) share one loader model; results are scored against a reference product.
module tb_matrix_mac_engine;
    import matrix_mac_engine_pkg::*;

    localparam coef_t C_ID  = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
    localparam coef_t C_MAX = '1;

    typedef struct {
        int x_mode;
        int stall_col;
        int stall_len;
        bit disturb;
        int exp_first_valid;
        int exp_done;
        int exp_n_req;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    int e0 = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- DUT wiring ----------------
    logic       start_r = 1'b0;
    logic       ld_ready = 1'b0;
    logic       spur_ready = 1'b0;
    logic [7:0] ld_e [4];
    logic [7:0] drv_e [4];
    state_e     dbg_d, dbg_i, dbg_m;

    matrix_mac_engine_if bus_d ();
    matrix_mac_engine_if bus_i ();
    matrix_mac_engine_if bus_m ();

    always_comb begin
        for (int k = 0; k < 4; k++) drv_e[k] = spur_ready ? 8'hEE : ld_e[k];
    end

    assign bus_d.start = start_r;
    assign bus_d.input_ready = ld_ready | spur_ready;
    assign bus_d.element1 = drv_e[0];
    assign bus_d.element2 = drv_e[1];
    assign bus_d.element3 = drv_e[2];
    assign bus_d.element4 = drv_e[3];
    assign bus_i.start = start_r;
    assign bus_i.input_ready = ld_ready | spur_ready;
    assign bus_i.element1 = drv_e[0];
    assign bus_i.element2 = drv_e[1];
    assign bus_i.element3 = drv_e[2];
    assign bus_i.element4 = drv_e[3];
    assign bus_m.start = start_r;
    assign bus_m.input_ready = ld_ready | spur_ready;
    assign bus_m.element1 = drv_e[0];
    assign bus_m.element2 = drv_e[1];
    assign bus_m.element3 = drv_e[2];
    assign bus_m.element4 = drv_e[3];

    matrix_mac_engine dut (.clk(clk), .reset(reset), .bus(bus_d), .dbg_state(dbg_d));
    matrix_mac_engine #(.COEFS(C_ID)) dut_id (.clk(clk), .reset(reset), .bus(bus_i), .dbg_state(dbg_i));
    matrix_mac_engine #(.COEFS(C_MAX)) dut_max (.clk(clk), .reset(reset), .bus(bus_m), .dbg_state(dbg_m));

    // ---------------- loader model ----------------
    int x_mat [4][8];
    int ld_cnt = 0;
    int ld_wait = 0;
    bit ld_pend = 1'b0;
    int stall_col = -1;
    int stall_len = 0;

    // Samples input_start mid-cycle and raises input_ready for the following full cycle.
    initial begin
        for (int k = 0; k < 4; k++) ld_e[k] = 8'h00;
        forever begin
            @(negedge clk);
            ld_ready = 1'b0;
            if (reset) begin
                ld_cnt  = 0;
                ld_pend = 1'b0;
            end else begin
                if (ld_pend) begin
                    if (ld_wait == 0) begin
                        for (int k = 0; k < 4; k++) ld_e[k] = 8'(x_mat[k][ld_cnt]);
                        ld_ready = 1'b1;
                        ld_cnt   = (ld_cnt + 1) % 8;
                        ld_pend  = 1'b0;
                    end else begin
                        ld_wait--;
                    end
                end
                if (bus_d.input_start) begin
                    ld_pend = 1'b1;
                    ld_wait = (ld_cnt == stall_col) ? stall_len : 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [22:0] cap_d_q[$], cap_i_q[$], cap_m_q[$];
    int req_q[$], done_q[$], valid_rel_q[$];
    int busy_first, busy_last, busy_cnt, mon_rel;
    bit mon_en = 1'b0;

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            mon_rel = cyc - e0 + 1;
            if (bus_d.result_valid) begin
                cap_d_q.push_back({bus_d.result_row, bus_d.result_col, bus_d.result});
                valid_rel_q.push_back(mon_rel);
            end
            if (bus_i.result_valid) cap_i_q.push_back({bus_i.result_row, bus_i.result_col, bus_i.result});
            if (bus_m.result_valid) cap_m_q.push_back({bus_m.result_row, bus_m.result_col, bus_m.result});
            if (bus_d.input_start) req_q.push_back(mon_rel);
            if (bus_d.done) done_q.push_back(mon_rel);
            if (bus_d.busy) begin
                if (busy_first < 0) busy_first = mon_rel;
                busy_last = mon_rel;
                busy_cnt++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail = 0;
    int c_def [4][4] = '{'{3, 1, 4, 1}, '{5, 9, 2, 6}, '{255, 0, 7, 128}, '{2, 200, 17, 1}};
    logic [22:0] exp_d_q[$], exp_i_q[$], exp_m_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] model_y(input int inst, input int r, input int j);
        int s;
        int c;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            case (inst)
                0:       c = c_def[r][k];
                1:       c = (r == k) ? 1 : 0;
                default: c = 255;
            endcase
            s += c * x_mat[k][j];
        end
        return ACC_W'(s);
    endfunction

    task automatic load_x(input int mode);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++)
                case (mode)
                    0:       x_mat[k][j] = 16 * k + j;
                    1:       x_mat[k][j] = 255;
                    default: x_mat[k][j] = (37 * k + 11 * j + 5) % 256;
                endcase
    endtask

    task automatic build_exp();
        exp_d_q.delete();
        exp_i_q.delete();
        exp_m_q.delete();
        for (int j = 0; j < 8; j++)
            for (int r = 0; r < 4; r++) begin
                exp_d_q.push_back({2'(r), 3'(j), model_y(0, r, j)});
                exp_i_q.push_back({2'(r), 3'(j), model_y(1, r, j)});
                exp_m_q.push_back({2'(r), 3'(j), model_y(2, r, j)});
            end
    endtask

    task automatic clear_mon();
        cap_d_q.delete();
        cap_i_q.delete();
        cap_m_q.delete();
        req_q.delete();
        done_q.delete();
        valid_rel_q.delete();
        busy_first = -1;
        busy_last  = -1;
        busy_cnt   = 0;
    endtask

    task automatic cmp_stream(input string nm, input logic [22:0] cap[$], input logic [22:0] exp[$]);
        check({nm, " count"}, 64'(cap.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < cap.size()) check({nm, " result"}, 64'(cap[i]), 64'(exp[i]));
    endtask

    // ---------------- driver tasks ----------------
    function automatic int rel_now();
        return cyc - e0 + 1;
    endfunction

    task automatic wait_rel(input int r);
        while (rel_now() < r) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_r = 1'b1;
        e0 = cyc + 1;
        mon_en = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        load_x(v.x_mode);
        stall_col = v.stall_col;
        stall_len = v.stall_len;
        clear_mon();
        build_exp();
        pulse_start();
        if (v.disturb) begin
            wait_rel(22);
            start_r = 1'b1;
            @(negedge clk);
            start_r = 1'b0;
            spur_ready = 1'b1;
            @(negedge clk);
            spur_ready = 1'b0;
        end
        if (v.stall_col >= 0) begin
            wait_rel(20);
            check({nm, " stall state"}, 64'(dbg_d), 64'(WAIT));
            check({nm, " stall input_start"}, 64'(bus_d.input_start), 64'd0);
        end
        wait_rel(v.exp_done + 6);
        mon_en = 1'b0;
        cmp_stream({nm, " dut"}, cap_d_q, exp_d_q);
        cmp_stream({nm, " dut_id"}, cap_i_q, exp_i_q);
        cmp_stream({nm, " dut_max"}, cap_m_q, exp_m_q);
        check({nm, " request count"}, 64'(req_q.size()), 64'(v.exp_n_req));
        if (req_q.size() > 0) check({nm, " first request"}, 64'(req_q[0]), 64'd1);
        for (int i = 1; i < req_q.size(); i++)
            check({nm, " request gap"}, 64'(req_q[i] - req_q[i-1]),
                  64'((i == v.stall_col + 1) ? 6 + v.stall_len : 6));
        if (valid_rel_q.size() > 0) check({nm, " first valid"}, 64'(valid_rel_q[0]), 64'(v.exp_first_valid));
        check({nm, " done count"}, 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) check({nm, " done cycle"}, 64'(done_q[0]), 64'(v.exp_done));
        check({nm, " busy first"}, 64'(busy_first), 64'd1);
        check({nm, " busy last"}, 64'(busy_last), 64'(v.exp_done));
        check({nm, " busy cycles"}, 64'(busy_cnt), 64'(v.exp_done));
    endtask

    task automatic check_quiet(input string nm);
        check({nm, " busy"}, 64'(bus_d.busy), 64'd0);
        check({nm, " done"}, 64'(bus_d.done), 64'd0);
        check({nm, " result_valid"}, 64'(bus_d.result_valid), 64'd0);
        check({nm, " result"}, 64'(bus_d.result), 64'd0);
        check({nm, " result_row"}, 64'(bus_d.result_row), 64'd0);
        check({nm, " result_col"}, 64'(bus_d.result_col), 64'd0);
        check({nm, " input_start"}, 64'(bus_d.input_start), 64'd0);
        check({nm, " state"}, 64'(dbg_d), 64'(IDLE));
        check({nm, " state id"}, 64'(dbg_i), 64'(IDLE));
        check({nm, " state max"}, 64'(dbg_m), 64'(IDLE));
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs [4];

    initial begin
        vecs[0] = '{x_mode: 0, stall_col: -1, stall_len: 0,  disturb: 1'b0, exp_first_valid: 4, exp_done: 49, exp_n_req: 8};
        vecs[1] = '{x_mode: 1, stall_col: -1, stall_len: 0,  disturb: 1'b0, exp_first_valid: 4, exp_done: 49, exp_n_req: 8};
        vecs[2] = '{x_mode: 2, stall_col: -1, stall_len: 0,  disturb: 1'b1, exp_first_valid: 4, exp_done: 49, exp_n_req: 8};
        vecs[3] = '{x_mode: 0, stall_col: 2,  stall_len: 10, disturb: 1'b0, exp_first_valid: 4, exp_done: 59, exp_n_req: 8};

        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Reset in the middle of column 5 (its CALC spans cycles 33..36).
        load_x(0);
        stall_col = -1;
        clear_mon();
        pulse_start();
        wait_rel(34);
        check("pre-reset busy", 64'(bus_d.busy), 64'd1);
        #2 reset = 1'b1;
        #1 check_quiet("mid-run reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        mon_en = 1'b0;
        check("mid-run reset done pulses", 64'(done_q.size()), 64'd0);
        check_quiet("after reset idle");
        run_vec(vecs[0], "after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matrix_mac_engine.md
Name: matrix_mac_engine

Overview:
- Sits directly downstream of the input loader stage, which holds a 4x8 byte matrix X (row k = one 64-bit rotating register) and presents one column per request on element1..element4.
- After the loader's start pulse, this block requests the 8 columns one at a time and computes Y = C x X, where C is a fixed 4x4 unsigned coefficient matrix from the shared package.
- It streams 32 results (18-bit) out serially, column-major, then pulses done.

Parameters:
- DATA_W, 8, width of each element and coefficient
- N_ROWS, 4, rows of X and C; elements per column
- N_COLS, 8, columns of X; requests per run
- ACC_W, 18, result width: 2*DATA_W + clog2(N_ROWS), so no overflow is possible

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse from the loader: matrix X complete
- element1..element4  in  8 each  column elements X[0..3][j], valid in the cycle input_ready is high
- input_ready  in  1  one-cycle strobe from the loader: elements updated
- input_start  out  1  column request to the loader, one-cycle pulse
- result  out  18  Y[row][col], unsigned
- result_row  out  2  row index of result
- result_col  out  3  column index of result
- result_valid  out  1  result fields valid this cycle
- busy  out  1  high from accepting start until done
- done  out  1  one-cycle pulse after the last result

Behaviour:
- Reset: one clock, asynchronous and active-high. All outputs are registered.
  - When reset is asserted, every output goes to 0 immediately.
  - The state machine goes to IDLE; row and col counters and the column latch are cleared.
- States: IDLE, REQ, WAIT, CALC, FIN.
- IDLE:
  - start=1 at edge t moves to REQ and sets busy.
  - input_start is driven high for exactly cycle t+1.
- REQ (1 cycle):
  - Moves to WAIT.
  - input_start returns to 0.
  - input_start is never asserted for two consecutive cycles, because the loader rotates once per high cycle.
- WAIT:
  - When input_ready=1, latch element1..4 into col_reg[0..3], clear row to 0, and go to CALC.
  - No timeout; the block waits indefinitely.
- CALC (4 cycles, row r = 0..3):
  - result <= sum over k of C[r][k]*col_reg[k], computed with 4 parallel 8x8 multipliers and an adder tree, registered once.
  - result_valid, result_row = r and result_col = col are valid in the cycle after each CALC cycle.
  - After r=3: if col==N_COLS-1 go to FIN; otherwise increment col and go to REQ.
- FIN (1 cycle):
  - done=1 for one cycle.
  - busy clears on the following edge.
  - col resets to 0 and the machine returns to IDLE.
- Timing:
  - Per column: 6 cycles (REQ, WAIT with ready arriving one cycle later, 4 CALC).
  - First result_valid appears 4 cycles after the start edge.
  - Full run: 48 cycles plus FIN. After exactly 8 requests the loader's registers are back in their original rotation.
- Boundary conditions:
  - start while busy: ignored, no restart.
  - input_ready outside WAIT: ignored, latch unchanged.
  - start and input_ready in the same cycle in IDLE: start is taken, ready is dropped.
  - Reset mid-run: aborts immediately; done is not pulsed; the next start begins again at column 0. The loader is reset by the same system reset.
- Arithmetic: unsigned only; zero-extend before summing. Maximum is 4*255*255 = 260100, which is less than 2^18, so there is no saturation logic.

Decomposition:
- Shared package holds:
  - Constants DATA_W, N_ROWS, N_COLS, ACC_W.
  - Coefficient array COEF[4][4] of 8-bit unsigned.
  - State enum {IDLE, REQ, WAIT, CALC, FIN}.
- One sub-module, mac_dot4: combinational 4-term unsigned dot product (four 8-bit pairs to 18 bits). It is instantiated once and fed COEF[row].
- The state machine, counters and output registers stay in the top module.

Test Plan:
- Identity: COEF = I; X[k][j] = 16*k + j; one start pulse.
  - Expect 32 results with Y[r][j] = 16*r + j, in order (col0 rows 0-3, col1, ...).
  - Expect exactly 8 input_start pulses spaced 6 cycles apart, and done at cycle 49 after start.
- Max magnitude: COEF all 255, X all 255.
  - Every result is 260100; no overflow.
- Timing: start at cycle 0, loader model returns input_ready 1 cycle after input_start.
  - First result_valid at cycle 4 with row 0 / col 0.
  - busy high from cycle 1 until the cycle after done.
- Ignore rules: second start pulse in the middle of column 3, plus a spurious input_ready during CALC.
  - Result stream is identical to the clean run; col_reg is unchanged.
- Mid-run reset: assert reset in the middle of column 5.
  - All outputs are 0 immediately and no done pulse occurs.
  - A new start yields the full 32-result sequence from col 0.
- Stall: loader model delays input_ready by 10 cycles for column 2.
  - Block holds WAIT with input_start low and resumes with correct results.
